// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared HEVC 4-point transform constants and width helper
package dct_pkg;

    localparam int COEF_64 = 64;
    localparam int COEF_83 = 83;
    localparam int COEF_36 = 36;

    // Headroom above the coefficient width so butterfly sums never overflow.
    localparam int ACC_GUARD = 9;

    // Accumulator width for the default 16-bit coefficient path.
    localparam int ACC_W = 16 + ACC_GUARD;

    function automatic int acc_width(input int width_c);
        return width_c + ACC_GUARD;
    endfunction

endpackage

// File: rtl/bloque_inv_if.sv
// rtl/bloque_inv_if.sv - coefficient-in / residual-out handshake bundle
interface bloque_inv_if #(
    parameter int WIDTH_C = 16,
    parameter int WIDTH_R = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [WIDTH_C-1:0] c0;
    logic signed [WIDTH_C-1:0] c1;
    logic signed [WIDTH_C-1:0] c2;
    logic signed [WIDTH_C-1:0] c3;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [WIDTH_R-1:0] y0;
    logic signed [WIDTH_R-1:0] y1;
    logic signed [WIDTH_R-1:0] y2;
    logic signed [WIDTH_R-1:0] y3;

    // Upstream coefficient buffer / downstream reconstruction adder side.
    modport master (
        output in_valid, c0, c1, c2, c3, out_ready,
        input  in_ready, out_valid, y0, y1, y2, y3
    );

    // Transform block side.
    modport slave (
        input  in_valid, c0, c1, c2, c3, out_ready,
        output in_ready, out_valid, y0, y1, y2, y3
    );
endinterface

// File: rtl/bloque_rnd_clip.sv
// rtl/bloque_rnd_clip.sv - round-half-up, arithmetic right shift and saturate
module bloque_rnd_clip #(
    parameter int IN_W  = 25,
    parameter int OUT_W = 16,
    parameter int SHIFT = 7
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    // One guard bit keeps the rounding add from wrapping at the top of the range.
    localparam logic signed [IN_W:0] RND  = (IN_W+1)'(1) <<< (SHIFT - 1);
    localparam logic signed [IN_W:0] MAXV = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MINV = {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] shifted;

    // Floor shift of the rounded value, then clamp to the output range.
    always_comb begin
        sum     = {din[IN_W-1], din} + RND;
        shifted = sum >>> SHIFT;
        if (shifted > MAXV) begin
            dout = MAXV[OUT_W-1:0];
        end else if (shifted < MINV) begin
            dout = MINV[OUT_W-1:0];
        end else begin
            dout = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/bloque_inv.sv
// rtl/bloque_inv.sv - 3-stage 4-point inverse HEVC core transform
module bloque_inv
    import dct_pkg::*;
#(
    parameter int WIDTH_C = 16,
    parameter int WIDTH_R = 16,
    parameter int SHIFT   = 7
) (
    input  logic        clk,
    input  logic        rst,
    bloque_inv_if.slave bus
);

    localparam int ACC_W = acc_width(WIDTH_C);
    localparam logic signed [ACC_W-1:0] K64 = ACC_W'(COEF_64);
    localparam logic signed [ACC_W-1:0] K83 = ACC_W'(COEF_83);
    localparam logic signed [ACC_W-1:0] K36 = ACC_W'(COEF_36);

    generate
        if (SHIFT < 1) begin : g_shift_check
            $error("bloque_inv: SHIFT must be >= 1");
        end
    endgenerate

    logic en;
    logic out_valid_q;

    // A held output that downstream refuses freezes every stage at once.
    assign en           = !(out_valid_q && !bus.out_ready);
    assign bus.in_ready = en;

    logic                      v1;
    logic signed [WIDTH_C-1:0] c0_q, c1_q, c2_q, c3_q;

    // S1: capture the coefficient column on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1   <= 1'b0;
            c0_q <= '0;
            c1_q <= '0;
            c2_q <= '0;
            c3_q <= '0;
        end else if (en) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                c0_q <= bus.c0;
                c1_q <= bus.c1;
                c2_q <= bus.c2;
                c3_q <= bus.c3;
            end
        end
    end

    logic signed [ACC_W-1:0] a0, a1, a2, a3;
    logic signed [ACC_W-1:0] e0_d, e1_d, o0_d, o1_d;

    // Even/odd butterfly products on sign-extended coefficients.
    always_comb begin
        a0   = {{(ACC_W-WIDTH_C){c0_q[WIDTH_C-1]}}, c0_q};
        a1   = {{(ACC_W-WIDTH_C){c1_q[WIDTH_C-1]}}, c1_q};
        a2   = {{(ACC_W-WIDTH_C){c2_q[WIDTH_C-1]}}, c2_q};
        a3   = {{(ACC_W-WIDTH_C){c3_q[WIDTH_C-1]}}, c3_q};
        e0_d = K64 * (a0 + a2);
        e1_d = K64 * (a0 - a2);
        o0_d = K83 * a1 + K36 * a3;
        o1_d = K36 * a1 - K83 * a3;
    end

    logic                    v2;
    logic signed [ACC_W-1:0] e0_q, e1_q, o0_q, o1_q;

    // S2: register the partial butterfly terms.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2   <= 1'b0;
            e0_q <= '0;
            e1_q <= '0;
            o0_q <= '0;
            o1_q <= '0;
        end else if (en) begin
            v2 <= v1;
            if (v1) begin
                e0_q <= e0_d;
                e1_q <= e1_d;
                o0_q <= o0_d;
                o1_q <= o1_d;
            end
        end
    end

    logic signed [ACC_W-1:0]   r0, r1, r2, r3;
    logic signed [WIDTH_R-1:0] y0_d, y1_d, y2_d, y3_d;

    // Final butterfly combine ahead of rounding.
    always_comb begin
        r0 = e0_q + o0_q;
        r1 = e1_q + o1_q;
        r2 = e1_q - o1_q;
        r3 = e0_q - o0_q;
    end

    bloque_rnd_clip #(.IN_W(ACC_W), .OUT_W(WIDTH_R), .SHIFT(SHIFT)) u_rc0 (.din(r0), .dout(y0_d));
    bloque_rnd_clip #(.IN_W(ACC_W), .OUT_W(WIDTH_R), .SHIFT(SHIFT)) u_rc1 (.din(r1), .dout(y1_d));
    bloque_rnd_clip #(.IN_W(ACC_W), .OUT_W(WIDTH_R), .SHIFT(SHIFT)) u_rc2 (.din(r2), .dout(y2_d));
    bloque_rnd_clip #(.IN_W(ACC_W), .OUT_W(WIDTH_R), .SHIFT(SHIFT)) u_rc3 (.din(r3), .dout(y3_d));

    logic signed [WIDTH_R-1:0] y0_q, y1_q, y2_q, y3_q;

    // S3: register the clipped residuals; they hold until downstream takes them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            y0_q        <= '0;
            y1_q        <= '0;
            y2_q        <= '0;
            y3_q        <= '0;
        end else if (en) begin
            out_valid_q <= v2;
            if (v2) begin
                y0_q <= y0_d;
                y1_q <= y1_d;
                y2_q <= y2_d;
                y3_q <= y3_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.y0        = y0_q;
    assign bus.y1        = y1_q;
    assign bus.y2        = y2_q;
    assign bus.y3        = y3_q;

endmodule

// File: tb/tb_bloque_inv.sv
// tb/tb_bloque_inv.sv - directed, backpressure and random checks of bloque_inv
module tb_bloque_inv;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    bloque_inv_if #(.WIDTH_C(16), .WIDTH_R(16)) bus ();

    bloque_inv #(.WIDTH_C(16), .WIDTH_R(16), .SHIFT(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string name;
        int c0, c1, c2, c3;
        int y0, y1, y2, y3;
    } vec_t;

    typedef struct {
        int y0, y1, y2, y3;
    } yv_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int rc(input longint r);
        longint t;
        t = (r + 64) >>> 7;
        if (t > 32767) return 32767;
        if (t < -32768) return -32768;
        return int'(t);
    endfunction

    function automatic yv_t model(input int c0, input int c1, input int c2, input int c3);
        longint e0, e1, o0, o1;
        yv_t y;
        e0 = 64 * (longint'(c0) + c2);
        e1 = 64 * (longint'(c0) - c2);
        o0 = 83 * longint'(c1) + 36 * longint'(c3);
        o1 = 36 * longint'(c1) - 83 * longint'(c3);
        y.y0 = rc(e0 + o0);
        y.y1 = rc(e1 + o1);
        y.y2 = rc(e1 - o1);
        y.y3 = rc(e0 - o0);
        return y;
    endfunction

    task automatic one_shot(input vec_t v);
        int lat;
        bit seen;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.c0 = 16'(v.c0);
        bus.c1 = 16'(v.c1);
        bus.c2 = 16'(v.c2);
        bus.c3 = 16'(v.c3);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (bus.out_valid) seen = 1'b1;
        end
        check({v.name, "_latency"}, lat, 3);
        check({v.name, "_y0"}, bus.y0, v.y0);
        check({v.name, "_y1"}, bus.y1, v.y1);
        check({v.name, "_y2"}, bus.y2, v.y2);
        check({v.name, "_y3"}, bus.y3, v.y3);
    endtask

    task automatic stream(input int nvec, input bit rand_mode);
        yv_t q[$];
        yv_t e;
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        bit stalled_prev = 1'b0;
        int py0 = 0, py1 = 0, py2 = 0, py3 = 0;
        while ((sent < nvec || q.size() > 0) && cyc < nvec * 6 + 50) begin
            @(negedge clk);
            cyc++;
            if (rand_mode) bus.out_ready = ($urandom_range(0, 9) < 7);
            else           bus.out_ready = !(cyc >= 4 && cyc <= 7);
            if (sent < nvec) begin
                if (rand_mode) begin
                    bus.in_valid = ($urandom_range(0, 9) < 7);
                    bus.c0 = 16'($urandom);
                    bus.c1 = 16'($urandom);
                    bus.c2 = 16'($urandom);
                    bus.c3 = 16'($urandom);
                end else begin
                    bus.in_valid = 1'b1;
                    bus.c0 = 16'(64 * (sent + 1));
                    bus.c1 = '0;
                    bus.c2 = '0;
                    bus.c3 = '0;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            check("in_ready_vs_stall", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            if (stalled_prev) begin
                check("stall_hold_valid", bus.out_valid, 1);
                check("stall_hold_y0", bus.y0, py0);
                check("stall_hold_y3", bus.y3, py3);
                check("stall_hold_y12", {bus.y1, bus.y2}, {16'(py1), 16'(py2)});
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(int'(bus.c0), int'(bus.c1), int'(bus.c2), int'(bus.c3)));
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    got++;
                    check("stream_y0", bus.y0, e.y0);
                    check("stream_y1", bus.y1, e.y1);
                    check("stream_y2", bus.y2, e.y2);
                    check("stream_y3", bus.y3, e.y3);
                end
            end
            stalled_prev = bus.out_valid && !bus.out_ready;
            py0 = bus.y0;
            py1 = bus.y1;
            py2 = bus.y2;
            py3 = bus.y3;
        end
        bus.in_valid = 1'b0;
        check("stream_sent", sent, nvec);
        check("stream_received", got, nvec);
    endtask

    vec_t tbl[6];
    bit   leaked;

    initial begin
        tbl[0] = '{"dc",      64, 0, 0, 0, 32, 32, 32, 32};
        tbl[1] = '{"odd1",    0, 64, 0, 0, 42, 18, -18, -41};
        tbl[2] = '{"even2",   0, 0, 64, 0, 32, -32, -32, 32};
        tbl[3] = '{"odd3",    0, 0, 0, 64, 18, -41, 42, -18};
        tbl[4] = '{"sat_pos", 32767, 32767, 32767, 32767, 32767, -12032, 12032, 2304};
        tbl[5] = '{"sat_neg", -32768, -32768, -32768, -32768, -32768, 12032, -12032, -2304};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.c0 = '0;
        bus.c1 = '0;
        bus.c2 = '0;
        bus.c3 = '0;

        // Reset held with garbage on the inputs.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom);
            bus.c0 = 16'($urandom);
            bus.c1 = 16'($urandom);
            bus.c2 = 16'($urandom);
            bus.c3 = 16'($urandom);
            bus.out_ready = 1'($urandom);
            #1;
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_y", {bus.y0, bus.y1, bus.y2, bus.y3}, 0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_release_out_valid", bus.out_valid, 0);

        for (int i = 0; i < 6; i++) one_shot(tbl[i]);

        stream(6, 1'b0);

        // Three vectors stuck in flight, then an asynchronous reset.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.c0 = 16'(64 * (i + 1));
            bus.c1 = '0;
            bus.c2 = '0;
            bus.c3 = '0;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("inflight_out_valid", bus.out_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_out_valid", bus.out_valid, 0);
        check("async_rst_y0", bus.y0, 0);
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        leaked = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) leaked = 1'b1;
        end
        check("post_rst_no_emit", leaked, 0);

        stream(10000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
